// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and ALU opcode encoding for the pipeline
package pipe_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_PASS = 4'h9
  } alu_op_e;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - operand bypass mux: EX/MEM result over register-file write port over raw read
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     raw_data,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     data
);

  // Youngest producer wins: MEM stage result is newer than the write-back port
  always_comb begin
    data = raw_data;
    if (mem_reg_write && (mem_addr == addr)) begin
      data = mem_data;
    end else if (wb_reg_write && (wb_addr == addr)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic [REG_ADDR_W-1:0] id_src_addr,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_op_a,
  output logic [DATA_W-1:0]     ex_op_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  stall
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b_next;
  logic              load_use;

  fwd_sel u_fwd_a (
    .addr          (id_dst_addr),
    .raw_data      (id_rd1),
    .mem_reg_write (mem_reg_write),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .wb_reg_write  (wb_reg_write),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .data          (fwd_a)
  );

  fwd_sel u_fwd_b (
    .addr          (id_src_addr),
    .raw_data      (id_rd2),
    .mem_reg_write (mem_reg_write),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .wb_reg_write  (wb_reg_write),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .data          (fwd_b)
  );

  // Immediate always beats bypassed data on B; stores still need the bypassed register
  assign op_b_next = id_use_imm ? id_imm : fwd_b;

  // A load in EX cannot feed ID this cycle; the source port only matters when it is read
  assign load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write &
                    ((ex_dst_addr == id_dst_addr) |
                     ((ex_dst_addr == id_src_addr) & ~id_use_imm));

  assign stall = (load_use | ex_hold) & ~flush;

  // Stage register: flush > hold > bubble > capture; data fields are left alone when squashed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_store_data <= '0;
      ex_dst_addr   <= '0;
      ex_alu_op     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
    end else if (!ex_hold) begin
      if (load_use) begin
        ex_valid      <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
      end else begin
        ex_valid      <= id_valid;
        ex_op_a       <= fwd_a;
        ex_op_b       <= op_b_next;
        ex_store_data <= fwd_b;
        ex_dst_addr   <= id_dst_addr;
        ex_alu_op     <= id_alu_op;
        ex_reg_write  <= id_valid & id_reg_write;
        ex_mem_read   <= id_valid & id_mem_read;
        ex_mem_write  <= id_valid & id_mem_write;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [15:0] id_rd1, id_rd2, id_imm;
  logic [2:0]  id_dst_addr, id_src_addr;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;
  logic [2:0]  mem_addr, wb_addr;
  logic [15:0] mem_data, wb_data;
  logic        flush, ex_hold;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [15:0] ex_op_a, ex_op_b, ex_store_data;
  logic [2:0]  ex_dst_addr;
  logic [3:0]  ex_alu_op;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_dst_addr(id_dst_addr), .id_src_addr(id_src_addr), .id_alu_op(id_alu_op),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the EX-side contents
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [15:0] m_a, m_b, m_sd;
  logic [2:0]  m_dst;
  logic [3:0]  m_op;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value of register r as the instruction in ID should see it
  function automatic logic [15:0] reg_view(input logic [2:0] r, input logic [15:0] raw);
    if (mem_reg_write && mem_addr == r) return mem_data;
    if (wb_reg_write && wb_addr == r) return wb_data;
    return raw;
  endfunction

  function automatic bit hazard_now();
    bit reads_dst, reads_src;
    reads_dst = (m_dst == id_dst_addr);
    reads_src = (m_dst == id_src_addr) && !id_use_imm;
    return id_valid && m_valid && m_mr && m_rw && (reads_dst || reads_src);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_a = 0; m_b = 0; m_sd = 0; m_dst = 0; m_op = 0;
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_reg_write", ex_reg_write, m_rw);
    chk("ex_mem_read", ex_mem_read, m_mr);
    chk("ex_mem_write", ex_mem_write, m_mw);
    if (m_valid) begin
      chk("ex_op_a", ex_op_a, m_a);
      chk("ex_op_b", ex_op_b, m_b);
      chk("ex_store_data", ex_store_data, m_sd);
      chk("ex_dst_addr", ex_dst_addr, m_dst);
      chk("ex_alu_op", ex_alu_op, m_op);
    end
  endtask

  // Inputs already driven; checks stall, clocks once, then checks registered outputs
  task automatic step();
    bit hz;
    #1;
    hz = hazard_now();
    chk("stall", stall, (hz || ex_hold) && !flush);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else if (ex_hold) begin
      // contents frozen
    end else if (hz) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else begin
      m_valid = id_valid;
      m_a     = reg_view(id_dst_addr, id_rd1);
      m_sd    = reg_view(id_src_addr, id_rd2);
      m_b     = id_use_imm ? id_imm : m_sd;
      m_dst   = id_dst_addr;
      m_op    = id_alu_op;
      m_rw    = id_valid && id_reg_write;
      m_mr    = id_valid && id_mem_read;
      m_mw    = id_valid && id_mem_write;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_dst_addr = 0; id_src_addr = 0;
    id_alu_op = 0; id_imm = 0; id_use_imm = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0;
    mem_reg_write = 0; mem_addr = 0; mem_data = 0;
    wb_reg_write = 0; wb_addr = 0; wb_data = 0;
    flush = 0; ex_hold = 0;
  endtask

  task automatic flush_cycle();
    idle_inputs();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic set_instr(input logic [2:0] dst, input logic [15:0] rd1, input logic [2:0] src,
                           input logic [15:0] rd2, input logic use_imm, input logic [15:0] imm,
                           input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_dst_addr = dst; id_rd1 = rd1; id_src_addr = src; id_rd2 = rd2;
    id_use_imm = use_imm; id_imm = imm; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_alu_op = 4'h1;
  endtask

  typedef struct {
    logic valid; logic [2:0] dst; logic [15:0] rd1; logic [2:0] src; logic [15:0] rd2;
    logic use_imm; logic [15:0] imm; logic rw; logic mr; logic mw;
    logic mrw; logic [2:0] maddr; logic [15:0] mdata;
    logic wrw; logic [2:0] waddr; logic [15:0] wdata;
    logic e_valid; logic e_rw; logic [15:0] e_a; logic [15:0] e_b; logic [15:0] e_sd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 3'd3, 16'h0001, 3'd1, 16'h2222, 0, 16'h0000, 1, 0, 0,
                1, 3'd3, 16'hABCD, 1, 3'd3, 16'h1111, 1, 1, 16'hABCD, 16'h2222, 16'h2222};
    vecs[1] = '{1, 3'd2, 16'h0005, 3'd0, 16'h0F0F, 0, 16'h0000, 1, 0, 0,
                0, 3'd2, 16'hDEAD, 1, 3'd2, 16'h7777, 1, 1, 16'h7777, 16'h0F0F, 16'h0F0F};
    vecs[2] = '{1, 3'd4, 16'h4444, 3'd5, 16'h5555, 0, 16'h0000, 0, 0, 1,
                0, 3'd4, 16'hBEEF, 0, 3'd5, 16'hCAFE, 1, 0, 16'h4444, 16'h5555, 16'h5555};
    vecs[3] = '{1, 3'd6, 16'h0606, 3'd4, 16'h0404, 1, 16'h00FF, 1, 0, 1,
                1, 3'd4, 16'h5A5A, 1, 3'd4, 16'h9999, 1, 1, 16'h0606, 16'h00FF, 16'h5A5A};
    vecs[4] = '{0, 3'd1, 16'h1111, 3'd1, 16'h1111, 0, 16'h0000, 1, 1, 1,
                0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1, 3'd7, 16'h0007, 3'd7, 16'h0070, 0, 16'h0000, 1, 0, 0,
                1, 3'd7, 16'h1234, 1, 3'd7, 16'h4321, 1, 1, 16'h1234, 16'h1234, 16'h1234};
    vecs[6] = '{1, 3'd0, 16'h00A0, 3'd2, 16'h00B0, 0, 16'h0000, 1, 0, 0,
                1, 3'd3, 16'h3333, 1, 3'd2, 16'h2B2B, 1, 1, 16'h00A0, 16'h2B2B, 16'h2B2B};
  end

  initial begin
    idle_inputs();
    model_clear();
    rst = 1;
    #1;
    chk("reset ex_valid", ex_valid, 0);
    chk("reset ex_op_a", ex_op_a, 0);
    chk("reset ex_op_b", ex_op_b, 0);
    chk("reset ex_store_data", ex_store_data, 0);
    chk("reset ex_dst_addr", ex_dst_addr, 0);
    chk("reset ex_alu_op", ex_alu_op, 0);
    chk("reset ex_mem_read", ex_mem_read, 0);
    @(posedge clk);
    #1 rst = 0;

    // Directed single-cycle vectors, each from an empty EX stage
    for (int i = 0; i < 7; i++) begin
      flush_cycle();
      id_valid = vecs[i].valid; id_dst_addr = vecs[i].dst; id_rd1 = vecs[i].rd1;
      id_src_addr = vecs[i].src; id_rd2 = vecs[i].rd2; id_use_imm = vecs[i].use_imm;
      id_imm = vecs[i].imm; id_reg_write = vecs[i].rw; id_mem_read = vecs[i].mr;
      id_mem_write = vecs[i].mw; id_alu_op = 4'(i);
      mem_reg_write = vecs[i].mrw; mem_addr = vecs[i].maddr; mem_data = vecs[i].mdata;
      wb_reg_write = vecs[i].wrw; wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
      step();
      chk($sformatf("vec%0d ex_valid", i), ex_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d ex_reg_write", i), ex_reg_write, vecs[i].e_rw);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d ex_op_a", i), ex_op_a, vecs[i].e_a);
        chk($sformatf("vec%0d ex_op_b", i), ex_op_b, vecs[i].e_b);
        chk($sformatf("vec%0d ex_store_data", i), ex_store_data, vecs[i].e_sd);
      end
    end

    // Load-use: one bubble, then capture with the load result bypassed from MEM
    flush_cycle();
    set_instr(3'd5, 16'h0000, 3'd0, 16'h0000, 1, 16'h0010, 1, 1, 0);
    step();
    set_instr(3'd2, 16'h0002, 3'd5, 16'h0BAD, 0, 16'h0000, 1, 0, 0);
    #1 chk("loaduse stall", stall, 1);
    step();
    chk("loaduse bubble ex_valid", ex_valid, 0);
    chk("loaduse bubble ex_reg_write", ex_reg_write, 0);
    mem_reg_write = 1; mem_addr = 3'd5; mem_data = 16'hC0DE;
    #1 chk("loaduse released stall", stall, 0);
    step();
    chk("loaduse capture ex_valid", ex_valid, 1);
    chk("loaduse capture ex_op_b", ex_op_b, 16'hC0DE);

    // Hold for three cycles with everything upstream changing
    flush_cycle();
    set_instr(3'd1, 16'h1357, 3'd2, 16'h2468, 0, 16'h0000, 1, 0, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      ex_hold = 1;
      id_rd1 = 16'($urandom); id_rd2 = 16'($urandom); id_dst_addr = 3'($urandom);
      id_src_addr = 3'($urandom); mem_reg_write = 1; mem_addr = 3'd1;
      mem_data = 16'($urandom); wb_reg_write = 1; wb_addr = 3'd2; wb_data = 16'($urandom);
      #1 chk("hold stall", stall, 1);
      step();
      chk("hold ex_op_a", ex_op_a, 16'h1357);
      chk("hold ex_op_b", ex_op_b, 16'h2468);
      chk("hold ex_store_data", ex_store_data, 16'h2468);
      chk("hold ex_valid", ex_valid, 1);
    end

    // Flush together with hold squashes the valid instruction
    flush = 1;
    #1 chk("flush+hold stall", stall, 0);
    step();
    chk("flush+hold ex_valid", ex_valid, 0);
    chk("flush+hold ex_reg_write", ex_reg_write, 0);
    ex_hold = 0; flush = 0;

    // Flush together with a load-use hazard never stalls
    idle_inputs();
    set_instr(3'd5, 16'h0000, 3'd0, 16'h0000, 1, 16'h0001, 1, 1, 0);
    step();
    set_instr(3'd3, 16'h0000, 3'd5, 16'h0000, 0, 16'h0000, 1, 0, 0);
    flush = 1;
    #1 chk("flush+hazard stall", stall, 0);
    step();
    chk("flush+hazard ex_valid", ex_valid, 0);
    flush = 0;

    // Reset between edges while a load sits in EX and the next op is stalled
    set_instr(3'd5, 16'hAAAA, 3'd0, 16'h0000, 1, 16'h0001, 1, 1, 0);
    step();
    set_instr(3'd4, 16'h0000, 3'd5, 16'h0055, 0, 16'h0000, 1, 0, 0);
    #1 chk("pre-reset stall", stall, 1);
    rst = 1;
    #1;
    chk("async rst ex_valid", ex_valid, 0);
    chk("async rst ex_op_a", ex_op_a, 0);
    chk("async rst ex_op_b", ex_op_b, 0);
    chk("async rst ex_dst_addr", ex_dst_addr, 0);
    chk("async rst ex_reg_write", ex_reg_write, 0);
    chk("async rst ex_mem_read", ex_mem_read, 0);
    #1 rst = 0;
    model_clear();
    chk("post-reset stall", stall, 0);
    step();
    chk("post-reset capture ex_op_b", ex_op_b, 16'h0055);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_rd1 = 16'($urandom); id_rd2 = 16'($urandom); id_imm = 16'($urandom);
      id_dst_addr = 3'($urandom_range(0, 3)); id_src_addr = 3'($urandom_range(0, 3));
      id_alu_op = 4'($urandom); id_use_imm = 1'($urandom);
      id_reg_write = ($urandom_range(0, 3) != 0); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom); mem_addr = 3'($urandom_range(0, 3)); mem_data = 16'($urandom);
      wb_reg_write = 1'($urandom); wb_addr = 3'($urandom_range(0, 3)); wb_data = 16'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
